// File: rtl/inst_buffer_pkg.sv
// Shared frontend constants and the instruction-buffer entry type.
package inst_buffer_pkg;

    localparam int BLOCK_INST_SIZE  = 8;
    localparam int PREDICTION_WIDTH = 3;
    localparam int FSQ_IDX_WIDTH    = 6;
    localparam int IBUF_DEPTH       = 16;
    localparam int DECODE_WIDTH     = 4;

    typedef struct packed {
        logic [31:0]                 inst;
        logic [FSQ_IDX_WIDTH-1:0]    fsqIdx;
        logic [PREDICTION_WIDTH-1:0] offset;
        logic                        ipf;
        logic                        iam;
    } IBufEntry;

endpackage

// File: rtl/inst_buffer_maskgen.sv
// MaskGen: prefix mask with the lowest num_i bits set.
module MaskGen #(
    parameter int WIDTH = 4
) (
    input  logic [$clog2(WIDTH):0] num_i,
    output logic [WIDTH-1:0]       mask_o
);
    localparam int NW = $clog2(WIDTH) + 1;

    always_comb begin
        mask_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_o[i] = (num_i > NW'(i));
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between predecode and decode.
// Define IBUF_BYPASS_EN to forward input slots straight to decode when the queue is empty.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH     = IBUF_DEPTH,
    parameter int IN_WIDTH  = BLOCK_INST_SIZE,
    parameter int OUT_WIDTH = DECODE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [IN_WIDTH-1:0]                  in_en,
    input  logic [$clog2(IN_WIDTH):0]            in_num,
    input  logic [IN_WIDTH*32-1:0]               in_inst,
    input  logic [FSQ_IDX_WIDTH-1:0]             in_fsqIdx,
    input  logic [IN_WIDTH*PREDICTION_WIDTH-1:0] in_offset,
    input  logic [IN_WIDTH-1:0]                  in_ipf,
    input  logic                                 in_iam,
    output logic                                 ibuf_full,
    output logic [OUT_WIDTH-1:0]                 out_valid,
    output logic [OUT_WIDTH*32-1:0]              out_inst,
    output logic [OUT_WIDTH*FSQ_IDX_WIDTH-1:0]   out_fsqIdx,
    output logic [OUT_WIDTH*PREDICTION_WIDTH-1:0] out_offset,
    output logic [OUT_WIDTH-1:0]                 out_ipf,
    output logic [OUT_WIDTH-1:0]                 out_iam,
    input  logic                                 dec_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int NW = $clog2(IN_WIDTH) + 1;
    localparam int OW = $clog2(OUT_WIDTH) + 1;
`ifdef IBUF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    IBufEntry         mem_q [DEPTH];
    IBufEntry         in_entry [IN_WIDTH];
    IBufEntry         rd_entry [OUT_WIDTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]    count, count_nxt;
    logic [PW-1:0]    enq_num, skip_num, deq_num;
    logic             full_q;
    logic [IN_WIDTH-1:0] wr_en;
    logic [AW-1:0]    wr_addr [IN_WIDTH];
    logic [OW-1:0]    rd_num;
    logic             byp_active;
    logic             unused_in_en;

    // in_num alone defines the valid slots; the mask is redundant.
    assign unused_in_en = ^in_en;
    assign count        = tail_q - head_q;
    assign ibuf_full    = full_q;

    always_comb begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            in_entry[i].inst   = in_inst[i*32 +: 32];
            in_entry[i].fsqIdx = in_fsqIdx;
            in_entry[i].offset = in_offset[i*PREDICTION_WIDTH +: PREDICTION_WIDTH];
            in_entry[i].ipf    = in_ipf[i];
            in_entry[i].iam    = in_iam;
        end
    end

    always_comb begin
        byp_active = BYPASS && (count == '0) && !flush;
        enq_num    = full_q ? '0 : PW'(in_num);
        if (byp_active) begin
            rd_num = (in_num > NW'(OUT_WIDTH)) ? OW'(OUT_WIDTH) : OW'(in_num);
        end else begin
            rd_num = (count > PW'(OUT_WIDTH)) ? OW'(OUT_WIDTH) : OW'(count);
        end
        skip_num = '0;
        deq_num  = '0;
        // Bypassed slots are consumed before they ever reach storage.
        if (!dec_stall) begin
            if (byp_active) skip_num = PW'(rd_num);
            else            deq_num  = PW'(rd_num);
        end
        head_d    = head_q + deq_num;
        tail_d    = tail_q + enq_num - skip_num;
        count_nxt = tail_d - head_d;
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_en[i]   = !flush && (PW'(i) >= skip_num) && (PW'(i) < enq_num);
            wr_addr[i] = AW'(tail_q + PW'(i) - skip_num);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            full_q <= 1'b0;
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
            full_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            full_q <= (count_nxt > PW'(DEPTH - IN_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (wr_en[i]) mem_q[wr_addr[i]] <= in_entry[i];
        end
    end

    always_comb begin
        out_inst   = '0;
        out_fsqIdx = '0;
        out_offset = '0;
        out_ipf    = '0;
        out_iam    = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            rd_entry[i] = mem_q[AW'(head_q + PW'(i))];
            if (byp_active) rd_entry[i] = in_entry[i];
            out_inst[i*32 +: 32]                             = rd_entry[i].inst;
            out_fsqIdx[i*FSQ_IDX_WIDTH +: FSQ_IDX_WIDTH]       = rd_entry[i].fsqIdx;
            out_offset[i*PREDICTION_WIDTH +: PREDICTION_WIDTH] = rd_entry[i].offset;
            out_ipf[i]                                       = rd_entry[i].ipf;
            out_iam[i]                                       = rd_entry[i].iam;
        end
    end

    MaskGen #(.WIDTH(OUT_WIDTH)) u_mask (
        .num_i  (rd_num),
        .mask_o (out_valid)
    );

    a_enq_while_full: assert property (@(posedge clk) disable iff (rst)
        !(full_q && !flush && (in_num != '0)));

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized bench for inst_buffer against a queue-based model, plus directed literal checks.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int IW  = BLOCK_INST_SIZE;
    localparam int OW  = DECODE_WIDTH;
    localparam int D   = IBUF_DEPTH;
    localparam int FW  = FSQ_IDX_WIDTH;
    localparam int PWD = PREDICTION_WIDTH;
    localparam int NB  = $clog2(IW) + 1;
`ifdef IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, flush, in_iam, dec_stall, ibuf_full;
    logic [IW-1:0]     in_en, in_ipf;
    logic [NB-1:0]     in_num;
    logic [IW*32-1:0]  in_inst;
    logic [FW-1:0]     in_fsqIdx;
    logic [IW*PWD-1:0] in_offset;
    logic [OW-1:0]     out_valid, out_ipf, out_iam;
    logic [OW*32-1:0]  out_inst;
    logic [OW*FW-1:0]  out_fsqIdx;
    logic [OW*PWD-1:0] out_offset;

    IBufEntry mq[$];
    bit       full_m;
    int       checks   = 0;
    int       failures = 0;

    inst_buffer dut (
        .clk(clk), .rst(rst), .flush(flush), .in_en(in_en), .in_num(in_num),
        .in_inst(in_inst), .in_fsqIdx(in_fsqIdx), .in_offset(in_offset),
        .in_ipf(in_ipf), .in_iam(in_iam), .ibuf_full(ibuf_full),
        .out_valid(out_valid), .out_inst(out_inst), .out_fsqIdx(out_fsqIdx),
        .out_offset(out_offset), .out_ipf(out_ipf), .out_iam(out_iam),
        .dec_stall(dec_stall)
    );

    always #5 clk = ~clk;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic IBufEntry in_slot(int i);
        IBufEntry e;
        e.inst   = in_inst[i*32 +: 32];
        e.fsqIdx = in_fsqIdx;
        e.offset = in_offset[i*PWD +: PWD];
        e.ipf    = in_ipf[i];
        e.iam    = in_iam;
        return e;
    endfunction

    function automatic IBufEntry out_slot(int i);
        IBufEntry e;
        e.inst   = out_inst[i*32 +: 32];
        e.fsqIdx = out_fsqIdx[i*FW +: FW];
        e.offset = out_offset[i*PWD +: PWD];
        e.ipf    = out_ipf[i];
        e.iam    = out_iam[i];
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        bit byp;
        int nv;
        byp = BYP && (mq.size() == 0) && !flush;
        nv  = byp ? imin(int'(in_num), OW) : imin(mq.size(), OW);
        chk("out_valid", 64'(out_valid), 64'((1 << nv) - 1));
        chk("ibuf_full", 64'(ibuf_full), 64'(full_m));
        for (int i = 0; i < nv; i++) begin
            chk($sformatf("slot%0d", i), 64'(out_slot(i)), 64'(byp ? in_slot(i) : mq[i]));
        end
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_update();
        bit byp;
        int d;
        if (flush) begin
            mq.delete();
            full_m = 1'b0;
            return;
        end
        byp = BYP && (mq.size() == 0);
        if (!byp && !dec_stall) begin
            d = imin(mq.size(), OW);
            repeat (d) void'(mq.pop_front());
        end
        if (!full_m) begin
            for (int i = 0; i < int'(in_num); i++) mq.push_back(in_slot(i));
        end
        if (byp && !dec_stall) begin
            d = imin(int'(in_num), OW);
            repeat (d) void'(mq.pop_front());
        end
        full_m = (mq.size() > D - IW);
    endtask

    task automatic apply(bit fl, bit st, int n, logic [31:0] base);
        @(negedge clk);
        flush     = fl;
        dec_stall = st;
        in_num    = NB'(n);
        in_en     = IW'((1 << n) - 1);
        in_fsqIdx = FW'($urandom);
        in_iam    = 1'($urandom);
        in_ipf    = IW'($urandom);
        for (int i = 0; i < IW; i++) begin
            in_inst[i*32 +: 32]     = base + 32'(i);
            in_offset[i*PWD +: PWD] = PWD'($urandom);
        end
        #1;
        compare_model();
        model_update();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dec_stall = 1'b1; in_num = '0; in_en = '0;
        in_inst = '0; in_fsqIdx = '0; in_offset = '0; in_ipf = '0; in_iam = 1'b0;
        full_m = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_full", 64'(ibuf_full), 64'h0);

        // enqueue 5 while stalled
        apply(0, 1, 5, 32'h100);
        apply(0, 1, 0, 32'h0);
        chk("enq5_valid", 64'(out_valid), 64'hF);
        for (int i = 0; i < OW; i++)
            chk($sformatf("enq5_inst%0d", i), 64'(out_inst[i*32 +: 32]), 64'(32'h100 + i));
        chk("enq5_full", 64'(ibuf_full), 64'h0);

        // fill to 12, then drain
        apply(1, 1, 0, 32'h0);
        apply(0, 1, 4, 32'h200);
        apply(0, 1, 4, 32'h210);
        apply(0, 1, 4, 32'h220);
        apply(0, 1, 0, 32'h0);
        chk("fill_full", 64'(ibuf_full), 64'h1);
        apply(0, 0, 0, 32'h0);
        apply(0, 1, 0, 32'h0);
        chk("drain_full", 64'(ibuf_full), 64'h0);
        chk("drain_inst0", 64'(out_inst[31:0]), 64'h210);

        // move pointers to 14, then enqueue 6 across the wrap
        apply(1, 1, 0, 32'h0);
        apply(0, 1, 8, 32'h300);
        apply(0, 1, 6, 32'h308);
        repeat (4) apply(0, 0, 0, 32'h0);
        apply(0, 1, 6, 32'h400);
        apply(0, 1, 0, 32'h0);
        chk("wrap_valid", 64'(out_valid), 64'hF);
        for (int i = 0; i < OW; i++)
            chk($sformatf("wrap_inst%0d", i), 64'(out_inst[i*32 +: 32]), 64'(32'h400 + i));

        // simultaneous enqueue 8 and dequeue 4 from count 6
        apply(0, 0, 8, 32'h500);
        apply(0, 1, 0, 32'h0);
        chk("sim_inst0", 64'(out_inst[31:0]),  64'h404);
        chk("sim_inst1", 64'(out_inst[63:32]), 64'h405);
        chk("sim_inst2", 64'(out_inst[95:64]), 64'h500);
        chk("sim_inst3", 64'(out_inst[127:96]), 64'h501);
        chk("sim_full", 64'(ibuf_full), 64'h1);

        // flush beats enqueue and dequeue
        apply(1, 0, 8, 32'h600);
        apply(0, 1, 0, 32'h0);
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_full", 64'(ibuf_full), 64'h0);

        // empty queue, enqueue 3 with decode ready
        apply(0, 0, 3, 32'h700);
        chk("byp_same_valid", 64'(out_valid), BYP ? 64'h7 : 64'h0);
        apply(0, 0, 0, 32'h0);
        chk("byp_next_valid", 64'(out_valid), BYP ? 64'h0 : 64'h7);

        for (int c = 0; c < 600; c++) begin
            automatic bit fl = ($urandom_range(0, 19) == 0);
            automatic bit st = ($urandom_range(0, 2) == 0);
            automatic int n  = full_m ? 0 : int'($urandom_range(0, IW));
            apply(fl, st, n, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
